gpr_op_sequencer: RTL

Multi-cycle initiator for the 16-bit general-purpose register file. It accepts one ALU instruction at a time over a valid/ready handshake and drives the register file's two read ports to fetch operands. It computes the result and writes it back through the register file write port. It sits between the instruction decoder and the register file, and is the only master of the register file's read-address and write ports.

---
 rtl/gpr_op_sequencer_pkg.sv | 28 ++
 rtl/gpr_op_sequencer_alu.sv | 33 +++
 rtl/gpr_op_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gpr_op_sequencer_pkg.sv
// Shared definitions for the GPR operation sequencer and its ALU.
package gpr_op_sequencer_pkg;

  localparam int GPR_DATA_W   = 16;
  localparam int GPR_ADDR_W   = 3;
  localparam int GPR_NUM_REGS = 3;
  localparam int GPR_IMM_W    = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_MOVI = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/gpr_op_sequencer_alu.sv
// Combinational ALU: DATA_W-bit result with carry/borrow in the top bit.
module gpr_op_alu
  import gpr_op_sequencer_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W
) (
  input  logic [2:0]           op,
  input  logic [DATA_W-1:0]    a,
  input  logic [DATA_W-1:0]    b,
  input  logic [GPR_IMM_W-1:0] imm,
  output logic [DATA_W:0]      result
);

  // Only ADD and SUB produce a nonzero top bit; shifts use the low four bits of b.
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_ADD:  result = {1'b0, a} + {1'b0, b};
      OP_SUB:  begin
        result[DATA_W-1:0] = a - b;
        result[DATA_W]     = (a < b);
      end
      OP_AND:  result = {1'b0, a & b};
      OP_OR:   result = {1'b0, a | b};
      OP_XOR:  result = {1'b0, a ^ b};
      OP_SHL:  result = {1'b0, a << b[3:0]};
      OP_SHR:  result = {1'b0, a >> b[3:0]};
      OP_MOVI: result = {1'b0, {(DATA_W-GPR_IMM_W){1'b0}}, imm};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/gpr_op_sequencer.sv
// Multi-cycle ALU instruction sequencer driving the GPR file read/write ports.
//
// state | meaning
// IDLE  | ready for an instruction; checks register addresses on accept
// READ  | read ports addressed with rs1/rs2; operands captured at end of cycle
// EXEC  | ALU result (with carry) registered
// WRITE | write strobe and done pulse; flags updated at end of cycle
// ERR   | one-cycle err pulse for an illegal register address, no write
module gpr_op_sequencer
  import gpr_op_sequencer_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int NUM_REGS = GPR_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [7:0]        instr_imm,
  output logic [ADDR_W-1:0] reg_read_addr_1,
  input  logic [DATA_W-1:0] reg_read_data_1,
  output logic [ADDR_W-1:0] reg_read_addr_2,
  input  logic [DATA_W-1:0] reg_read_data_2,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              done,
  output logic              err,
  output logic              flag_zero,
  output logic              flag_carry
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [7:0]        imm_q, imm_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;

  logic [DATA_W:0]   alu_result;
  logic              addr_illegal;

  gpr_op_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result)
  );

  // MOVI never reads its sources, so only rd is range-checked for it.
  always_comb begin
    addr_illegal = (instr_rd >= LIMIT);
    if (op_e'(instr_op) != OP_MOVI) begin
      addr_illegal = addr_illegal || (instr_rs1 >= LIMIT) || (instr_rs2 >= LIMIT);
    end
  end

  // State register and datapath flops; synchronous reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  // Next-state and datapath updates for each phase of the instruction.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d    = instr_op;
          rd_d    = instr_rd;
          rs1_d   = instr_rs1;
          rs2_d   = instr_rs2;
          imm_d   = instr_imm;
          state_d = addr_illegal ? ST_ERR : ST_READ;
        end
      end
      ST_READ: begin
        opa_d   = reg_read_data_1;
        opb_d   = reg_read_data_2;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_result;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        zero_d  = (result_q[DATA_W-1:0] == '0);
        carry_d = result_q[DATA_W];
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are gated with rst_n so a reset landing on WRITE/ERR suppresses them.
  always_comb begin
    instr_ready     = (state_q == ST_IDLE);
    reg_read_addr_1 = rs1_q;
    reg_read_addr_2 = rs2_q;
    reg_write_en    = rst_n && (state_q == ST_WRITE);
    reg_write_dest  = rd_q;
    reg_write_data  = result_q[DATA_W-1:0];
    done            = rst_n && (state_q == ST_WRITE);
    err             = rst_n && (state_q == ST_ERR);
    flag_zero       = zero_q;
    flag_carry      = carry_q;
  end

endmodule
